// File: rtl/maze_player_ctrl.sv
// Player movement controller sharing the maze ROM between the OLED pixel path and a wall checker.
// Composites the player sprite over the maze image and flags arrival in the goal box.
module maze_player_ctrl #(
    parameter int          P_SIZE   = 4,
    parameter int          START_X  = 4,
    parameter int          START_Y  = 30,
    parameter int          GOAL_X0  = 84,
    parameter int          GOAL_X1  = 92,
    parameter int          GOAL_Y0  = 52,
    parameter int          GOAL_Y1  = 60,
    parameter logic [15:0] WALL_COL = 16'hFFFF,
    parameter logic [15:0] P_COL    = 16'hF800
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pix_req,
    input  logic [12:0] i_pixel_index,
    input  logic        i_btn_up,
    input  logic        i_btn_dn,
    input  logic        i_btn_lt,
    input  logic        i_btn_rt,
    output logic [12:0] o_rom_index,
    input  logic [15:0] i_rom_data,
    output logic [15:0] o_oled_data,
    output logic [6:0]  o_player_x,
    output logic [5:0]  o_player_y,
    output logic        o_move_done,
    output logic        o_move_reject,
    output logic        o_goal_reached
);

    // state    | meaning
    // S_IDLE   | waiting for a button pulse
    // S_CHECK  | reading the target box's leading edge from the ROM
    // S_COMMIT | move_done / move_reject pulse is being presented
    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_COMMIT} state_t;
    typedef enum logic [1:0] {D_UP, D_DN, D_LT, D_RT} dir_t;

    state_t      r_state;
    dir_t        r_dir;
    logic [6:0]  r_px;
    logic [5:0]  r_py;
    logic [6:0]  r_tx;
    logic [5:0]  r_ty;
    logic [3:0]  r_k;
    logic [3:0]  r_eval;
    logic        r_hit;
    logic        r_move_done;
    logic        r_move_reject;
    logic        r_goal;

    logic [12:0] r_rom_index;
    logic        r_disp_pend;
    logic        r_disp_pend2;
    logic        r_chk_pend;
    logic        r_chk_pend2;
    logic [12:0] r_disp_idx;
    logic [12:0] r_disp_idx2;
    logic [15:0] r_oled;

    dir_t        w_dir;
    logic        w_btn_any;
    logic        w_can_move;
    logic [6:0]  w_tgt_x;
    logic [5:0]  w_tgt_y;
    logic [6:0]  w_edge_x;
    logic [5:0]  w_edge_y;
    logic [12:0] w_edge_addr;
    logic        w_chk_grant;
    logic        w_hit_final;
    logic        w_last_eval;
    logic        w_in_goal;
    logic        w_in_sprite;
    logic [12:0] w_row_base;

    assign w_btn_any = i_btn_up | i_btn_dn | i_btn_lt | i_btn_rt;

    always_comb begin
        w_dir = D_RT;
        if (i_btn_up)      w_dir = D_UP;
        else if (i_btn_dn) w_dir = D_DN;
        else if (i_btn_lt) w_dir = D_LT;
        else               w_dir = D_RT;
    end

    // The whole target box must stay on screen, so down/right limits account for the sprite size.
    always_comb begin
        w_tgt_x    = r_px;
        w_tgt_y    = r_py;
        w_can_move = 1'b0;
        case (w_dir)
            D_UP: begin
                w_tgt_y    = r_py - 6'd1;
                w_can_move = (r_py != 6'd0);
            end
            D_DN: begin
                w_tgt_y    = r_py + 6'd1;
                w_can_move = (r_py < 6'(64 - P_SIZE));
            end
            D_LT: begin
                w_tgt_x    = r_px - 7'd1;
                w_can_move = (r_px != 7'd0);
            end
            default: begin
                w_tgt_x    = r_px + 7'd1;
                w_can_move = (r_px < 7'(96 - P_SIZE));
            end
        endcase
    end

    always_comb begin
        w_edge_x = r_tx;
        w_edge_y = r_ty;
        case (r_dir)
            D_UP: w_edge_x = r_tx + 7'(r_k);
            D_DN: begin
                w_edge_x = r_tx + 7'(r_k);
                w_edge_y = r_ty + 6'(P_SIZE - 1);
            end
            D_LT: w_edge_y = r_ty + 6'(r_k);
            default: begin
                w_edge_x = r_tx + 7'(P_SIZE - 1);
                w_edge_y = r_ty + 6'(r_k);
            end
        endcase
    end

    assign w_edge_addr = 13'(w_edge_y) * 13'd96 + 13'(w_edge_x);
    assign w_chk_grant = (r_state == S_CHECK) && (r_k < 4'(P_SIZE)) && !i_pix_req;
    assign w_hit_final = r_hit | (i_rom_data == WALL_COL);
    assign w_last_eval = r_chk_pend2 && (r_eval == 4'(P_SIZE - 1));
    assign w_in_goal   = (r_px >= 7'(GOAL_X0)) && (r_px <= 7'(GOAL_X1)) &&
                         (r_py >= 6'(GOAL_Y0)) && (r_py <= 6'(GOAL_Y1));

    // Sprite hit test row by row on the linear index, avoiding a divide-by-96.
    always_comb begin
        w_in_sprite = 1'b0;
        w_row_base  = '0;
        for (int r = 0; r < P_SIZE; r++) begin
            w_row_base = (13'(r_py) + 13'(r)) * 13'd96 + 13'(r_px);
            if (r_disp_idx2 >= w_row_base && r_disp_idx2 < w_row_base + 13'(P_SIZE))
                w_in_sprite = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_dir         <= D_UP;
            r_px          <= 7'(START_X);
            r_py          <= 6'(START_Y);
            r_tx          <= '0;
            r_ty          <= '0;
            r_k           <= '0;
            r_eval        <= '0;
            r_hit         <= 1'b0;
            r_move_done   <= 1'b0;
            r_move_reject <= 1'b0;
            r_goal        <= 1'b0;
        end else begin
            r_move_done   <= 1'b0;
            r_move_reject <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_btn_any) begin
                        r_dir <= w_dir;
                        if (w_can_move) begin
                            r_tx    <= w_tgt_x;
                            r_ty    <= w_tgt_y;
                            r_k     <= '0;
                            r_eval  <= '0;
                            r_hit   <= 1'b0;
                            r_state <= S_CHECK;
                        end else begin
                            r_move_reject <= 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_chk_grant)
                        r_k <= r_k + 4'd1;
                    if (r_chk_pend2) begin
                        r_hit  <= w_hit_final;
                        r_eval <= r_eval + 4'd1;
                    end
                    // Pulse and position update are registered on entry so they are seen during COMMIT.
                    if (w_last_eval) begin
                        r_state <= S_COMMIT;
                        if (w_hit_final) begin
                            r_move_reject <= 1'b1;
                        end else begin
                            r_px        <= r_tx;
                            r_py        <= r_ty;
                            r_move_done <= 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    if (r_move_done && w_in_goal)
                        r_goal <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rom_index  <= '0;
            r_disp_pend  <= 1'b0;
            r_disp_pend2 <= 1'b0;
            r_chk_pend   <= 1'b0;
            r_chk_pend2  <= 1'b0;
            r_disp_idx   <= '0;
            r_disp_idx2  <= '0;
            r_oled       <= '0;
        end else begin
            r_disp_pend  <= i_pix_req;
            r_disp_pend2 <= r_disp_pend;
            r_chk_pend   <= w_chk_grant;
            r_chk_pend2  <= r_chk_pend;
            r_disp_idx2  <= r_disp_idx;
            if (i_pix_req) begin
                r_rom_index <= i_pixel_index;
                r_disp_idx  <= i_pixel_index;
            end else if (w_chk_grant) begin
                r_rom_index <= w_edge_addr;
            end
            if (r_disp_pend2)
                r_oled <= w_in_sprite ? P_COL : i_rom_data;
        end
    end

    assign o_rom_index    = r_rom_index;
    assign o_oled_data    = r_oled;
    assign o_player_x     = r_px;
    assign o_player_y     = r_py;
    assign o_move_done    = r_move_done;
    assign o_move_reject  = r_move_reject;
    assign o_goal_reached = r_goal;

endmodule
